// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: width codes, FSM states, grant owner.
package mem_arb_pkg;

   localparam logic [1:0] W_BYTE = 2'd0;
   localparam logic [1:0] W_HALF = 2'd1;
   localparam logic [1:0] W_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } grant_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane steering: store strobes/data and misalign detection from the live request,
// load extraction and extension from the latched request and returned word.
module lane_align
   import mem_arb_pkg::*;
(
   input  logic [1:0]  st_width,
   input  logic [1:0]  st_addr_lo,
   input  logic [31:0] st_data,
   output logic [3:0]  st_wstrb,
   output logic [31:0] st_wdata,
   output logic        misalign,
   input  logic [1:0]  ld_width,
   input  logic        ld_ext,
   input  logic [1:0]  ld_addr_lo,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_result
);

   logic [31:0] shifted;

   always_comb begin
      st_wstrb = '0;
      st_wdata = '0;
      case (st_width)
         W_BYTE: begin
            st_wstrb = 4'b0001 << st_addr_lo;
            st_wdata = {4{st_data[7:0]}};
         end
         W_HALF: begin
            st_wstrb = 4'b0011 << st_addr_lo;
            st_wdata = {2{st_data[15:0]}};
         end
         W_WORD: begin
            st_wstrb = 4'b1111;
            st_wdata = st_data;
         end
         default: begin
            st_wstrb = '0;
            st_wdata = '0;
         end
      endcase
   end

   assign misalign = ((st_width == W_HALF) && st_addr_lo[0])
                   || ((st_width == W_WORD) && (st_addr_lo != 2'b00))
                   || (st_width == 2'd3);

   always_comb begin
      shifted   = ld_rdata >> {ld_addr_lo, 3'b000};
      ld_result = '0;
      case (ld_width)
         W_BYTE:  ld_result = {{24{ld_ext & shifted[7]}}, shifted[7:0]};
         W_HALF:  ld_result = {{16{ld_ext & shifted[15]}}, shifted[15:0]};
         W_WORD:  ld_result = shifted;
         default: ld_result = '0;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_ena,
   input  logic [31:0] icache_addr,
   output logic        icache_valid,
   output logic [31:0] icache_data,
   input  logic        dcache_r_ena,
   input  logic        dcache_w_ena,
   input  logic        dcache_ext,
   input  logic [1:0]  dcache_width,
   input  logic [31:0] dcache_addr,
   input  logic [31:0] dcache_data_in,
   output logic        dcache_valid,
   output logic [31:0] dcache_data_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        misalign_err
);

   state_t      state_q, state_d;
   grant_t      gnt_q, gnt_d, last_q, last_d, pick;
   logic        wr_q, wr_d, ext_q, ext_d;
   logic [1:0]  wid_q, wid_d, lo_q, lo_d;
   logic        req_d, we_d, iv_d, dv_d, err_d;
   logic [31:0] addr_d, wdata_d, idata_d, ddata_d;
   logic [3:0]  wstrb_d;
   logic        i_pend, d_pend;
   logic [3:0]  al_wstrb;
   logic [31:0] al_wdata, al_ld;
   logic        al_mis;

   lane_align u_lane (
      .st_width   (dcache_width),
      .st_addr_lo (dcache_addr[1:0]),
      .st_data    (dcache_data_in),
      .st_wstrb   (al_wstrb),
      .st_wdata   (al_wdata),
      .misalign   (al_mis),
      .ld_width   (wid_q),
      .ld_ext     (ext_q),
      .ld_addr_lo (lo_q),
      .ld_rdata   (mem_rdata),
      .ld_result  (al_ld)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      wr_d    = wr_q;
      ext_d   = ext_q;
      wid_d   = wid_q;
      lo_d    = lo_q;
      req_d   = mem_req;
      we_d    = mem_we;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      wstrb_d = mem_wstrb;
      iv_d    = 1'b0;
      dv_d    = 1'b0;
      err_d   = 1'b0;
      idata_d = icache_data;
      ddata_d = dcache_data_out;
      i_pend  = icache_ena;
      d_pend  = dcache_r_ena | dcache_w_ena;
      pick    = GNT_I;

      case (state_q)
         IDLE: begin
            if (i_pend || d_pend) begin
               // On a tie the side that did not win last time goes first.
               if (!i_pend)      pick = GNT_D;
               else if (!d_pend) pick = GNT_I;
               else              pick = (last_q == GNT_I) ? GNT_D : GNT_I;
               gnt_d  = pick;
               last_d = pick;
               if (pick == GNT_I) begin
                  state_d = BUSY;
                  req_d   = 1'b1;
                  we_d    = 1'b0;
                  addr_d  = word_align(icache_addr);
                  wdata_d = '0;
                  wstrb_d = '0;
               end else begin
                  wr_d  = dcache_w_ena;
                  ext_d = dcache_ext;
                  wid_d = dcache_width;
                  lo_d  = dcache_addr[1:0];
                  if (al_mis) begin
                     state_d = RESP;
                     dv_d    = 1'b1;
                     err_d   = 1'b1;
                     ddata_d = '0;
                  end else begin
                     state_d = BUSY;
                     req_d   = 1'b1;
                     we_d    = dcache_w_ena;
                     addr_d  = word_align(dcache_addr);
                     wdata_d = dcache_w_ena ? al_wdata : '0;
                     wstrb_d = dcache_w_ena ? al_wstrb : '0;
                  end
               end
            end
         end
         BUSY: begin
            if (mem_ready) begin
               state_d = RESP;
               req_d   = 1'b0;
               if (gnt_q == GNT_I) begin
                  iv_d    = 1'b1;
                  idata_d = mem_rdata;
               end else begin
                  dv_d    = 1'b1;
                  ddata_d = wr_q ? '0 : al_ld;
               end
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         gnt_q           <= GNT_I;
         last_q          <= GNT_I;
         wr_q            <= 1'b0;
         ext_q           <= 1'b0;
         wid_q           <= '0;
         lo_q            <= '0;
         mem_req         <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         mem_wstrb       <= '0;
         icache_valid    <= 1'b0;
         dcache_valid    <= 1'b0;
         misalign_err    <= 1'b0;
         icache_data     <= '0;
         dcache_data_out <= '0;
      end else begin
         state_q         <= state_d;
         gnt_q           <= gnt_d;
         last_q          <= last_d;
         wr_q            <= wr_d;
         ext_q           <= ext_d;
         wid_q           <= wid_d;
         lo_q            <= lo_d;
         mem_req         <= req_d;
         mem_we          <= we_d;
         mem_addr        <= addr_d;
         mem_wdata       <= wdata_d;
         mem_wstrb       <= wstrb_d;
         icache_valid    <= iv_d;
         dcache_valid    <= dv_d;
         misalign_err    <= err_d;
         icache_data     <= idata_d;
         dcache_data_out <= ddata_d;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have fetch ports: icache_ena in 1 fetch request (held until served); icache_addr in 32; icache_valid out 1 one-cycle done pulse; icache_data out 32.
REQ-003 SHALL have data ports: dcache_r_ena in 1; dcache_w_ena in 1; dcache_ext in 1 (1 = sign-extend load); dcache_width in 2 (0 byte, 1 half, 2 word); dcache_addr in 32; dcache_data_in in 32 store data; dcache_valid out 1 one-cycle done pulse; dcache_data_out out 32 load result.
REQ-004 SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out 32 word-aligned; mem_wdata out 32; mem_wstrb out 4; mem_ready in 1; mem_rdata in 32.
REQ-005 SHALL have misalign_err out 1: one-cycle pulse coincident with dcache_valid for a misaligned data access.

Function
REQ-006 FSM states SHALL be IDLE, BUSY, RESP; reset state IDLE.
REQ-007 IDLE: pending = icache_ena (fetch) and/or dcache_r_ena|dcache_w_ena (data); with any pending -> BUSY next edge, grant latched.
REQ-008 Single pending requester SHALL win; when both pend, the requester not in last_grant wins; last_grant updates on every grant.
REQ-009 BUSY: mem_req=1 with mem_we/addr/wdata/wstrb registered and stable until mem_ready sampled 1; then -> RESP, mem_req=0, mem_rdata captured.
REQ-010 RESP: the granted side's valid=1 for exactly that cycle with registered data; -> IDLE unconditionally (requests are not re-sampled in RESP).
REQ-011 Minimum latency SHALL be: request seen at edge N, mem_req high N+1, mem_ready same cycle, valid high N+2; next grant no earlier than N+3.
REQ-012 dcache_r_ena and dcache_w_ena both high SHALL be treated as a write.
REQ-013 mem_addr SHALL be {addr[31:2],2'b00} for both sides; fetch ignores addr[1:0].
REQ-014 Store: byte -> wstrb = 1<<addr[1:0], wdata = data[7:0] replicated x4; half -> wstrb = 4'b0011<<addr[1:0], wdata = data[15:0] replicated x2; word -> wstrb 4'b1111, wdata = data.
REQ-015 Load: mem_rdata shifted right by 8*addr[1:0], truncated to width, zero-extended (ext=0) or sign-extended (ext=1); width word ignores ext.
REQ-016 Write completion SHALL pulse dcache_valid with dcache_data_out = 0.
REQ-017 Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or width=3) SHALL issue no memory transaction: IDLE -> RESP directly, dcache_data_out = 0, misalign_err=1; the grant still counts for last_grant.
REQ-018 Requester deasserting ena during BUSY SHALL not abort: the transaction completes and valid still pulses.
REQ-019 Fetch and data valid SHALL never be high in the same cycle.

Reset
REQ-020 On rst, asynchronously: state IDLE, mem_req/mem_we 0, mem_addr/mem_wdata 0, mem_wstrb 0, icache_valid/dcache_valid/misalign_err 0, icache_data/dcache_data_out 0, last_grant = fetch (so data wins the first tie).
REQ-021 rst during BUSY SHALL drop mem_req immediately; the memory model is expected to discard the transaction; no valid pulse follows.

Structure
REQ-022 Package mem_arb_pkg SHALL hold width encodings (W_BYTE=0, W_HALF=1, W_WORD=2), the FSM state enum and the grant encoding (GNT_I, GNT_D).
REQ-023 A combinational sub-module lane_align SHALL compute wstrb/wdata from (width, addr[1:0], data) and the load result from (width, ext, addr[1:0], rdata); the misalign flag is also produced there.
REQ-024 Target size 150-250 lines RTL total.

Verification
REQ-025 Fetch only: icache_ena=1, addr=0x104, mem_ready=1 always, rdata=0x00500093 -> mem_req at N+1 with addr 0x104, icache_valid at N+2 with data 0x00500093.
REQ-026 Tie after reset: both request at once -> data granted first, fetch granted next; second tie -> data again (alternation).
REQ-027 Signed byte load: width=0, ext=1, addr=0x203, rdata=0x80FF7F01 -> mem_addr 0x200, dcache_data_out 0xFFFFFF80; with ext=0 -> 0x00000080.
REQ-028 Half store: width=1, addr=0x102, data=0x1234ABCD -> mem_we=1, wstrb 4'b1100, wdata 0xABCDABCD; mem_ready delayed 3 cycles -> fields stable throughout, dcache_valid 1 cycle after ready.
REQ-029 Misaligned word load at 0x101 -> no mem_req, dcache_valid and misalign_err at N+1, data 0.
REQ-030 rst asserted during BUSY with mem_ready=0 -> mem_req drops in the same cycle, all outputs 0, no valid pulse; a fresh fetch after release completes normally.
